raycast_buffer_ctrl: RTL
========================

Name: raycast_buffer_ctrl

Overview:
- Ping-pong controller for the two column blockmems feeding raycast_buffer.
- Accepts a sequential column stream from the raycaster over a valid/ready handshake and writes it into the back bank.
- Swaps banks (buffer_sel) only at vertical-blank entry, once a complete frame has been written, so the display never reads a half-written bank.
- Pulses a frame-start strobe to the raycaster and counts missed swaps.

Parameters:
- ADDR_W, 10, blockmem address width.
- DATA_W, 10, column-height word width.
- NUM_COLS, 640, columns per frame; legal range 1..2**ADDR_W.
- VBLANK_LINE, 480, vp value marking vertical-blank entry.

Ports:
- i_clk  in  1  pixel clock, 20 MHz PLL domain.
- i_rst  in  1  synchronous, active-high reset.
- i_hp  in  10  VGA horizontal position.
- i_vp  in  10  VGA vertical position.
- i_wr_valid  in  1  raycaster column word valid.
- i_wr_data  in  DATA_W  column height.
- o_wr_ready  out  1  controller accepts a word this cycle.
- o_frame_start  out  1  one-cycle pulse: begin rendering next frame.
- o_wen1, o_wen2  out  1  write enables for bank 1 / bank 2.
- o_waddr1, o_waddr2  out  ADDR_W  write addresses.
- o_wdata1, o_wdata2  out  DATA_W  write data.
- o_buffer_sel  out  1  1 = display reads bank 1 and writer fills bank 2; 0 = the reverse.
- o_late_cnt  out  8  saturating count of vblanks where the back bank was incomplete.

Behaviour:
- Reset values: state=FILL, col=0, buffer_sel=1, wen1=wen2=0, waddr=0, wdata=0, frame_start=1 (pulse on the first cycle after reset), late_cnt=0, wr_ready=0 in the reset cycle.
- Reset mid-frame discards any partial frame.
- vblank_evt is asserted when i_vp==VBLANK_LINE && i_hp==0. It is single-cycle per frame.
- FILL state:
  - o_wr_ready=1.
  - Accept when i_wr_valid && o_wr_ready.
  - On accept: next cycle, the back-bank wen=1, waddr=col, wdata=i_wr_data. Write latency is 1 cycle, registered. The front-bank wen stays 0.
  - col increments on each accept.
  - The accept with col==NUM_COLS-1 moves to READY; col resets to 0.
- READY state:
  - o_wr_ready=0.
  - On vblank_evt: go to SWAP.
- SWAP state (1 cycle):
  - Toggle buffer_sel.
  - Pulse o_frame_start.
  - Go to FILL, or to CLEAR when the optional feature is enabled.
- vblank_evt while in FILL: no swap, late_cnt++ (saturates at 255), and filling continues uninterrupted.
- vblank_evt in the same cycle as the final accept: the state is not yet READY, so this counts as late. The swap waits for the next vblank.
- The write to the final column always completes in the cycle after the accept, which precedes any SWAP. No write ever targets the front bank.
- Idle bank outputs hold waddr/wdata and keep wen=0.

Optional Feature:
- Macro: RAYCAST_BUF_CLEAR_EN.
- Enabled:
  - After SWAP, enter CLEAR.
  - CLEAR writes 0 to back-bank addresses 0..NUM_COLS-1, one per cycle, with wr_ready=0.
  - CLEAR then enters FILL.
  - o_frame_start pulses on entry to FILL instead of in SWAP.
  - vblank during CLEAR increments late_cnt.
- Disabled: the CLEAR state and its counter logic are not compiled; SWAP goes directly to FILL.

Decomposition:
- Package raycast_pkg:
  - state enum: FILL, READY, SWAP, CLEAR.
  - constants NUM_COLS_DEF=640 and VBLANK_LINE_DEF=480.
  - bank_sel_t typedef.
- Sub-module bank_write_mux: given buffer_sel and one write request, drives the back bank's wen/waddr/wdata and holds the front bank's wen at 0. This is purely combinational plus the output register.

Test Plan:
- Reset, then stream 640 words with valid held high.
  - Expect 640 consecutive wen2 pulses, addr 0..639, data matching.
  - wen1 never high.
  - buffer_sel=1 until the first vblank.
  - At vp=480, hp=0: buffer_sel becomes 0 and frame_start pulses one cycle later.
- Throttle valid at 50% (alternating cycles).
  - Expect writes only on accepted cycles, with no address skips or repeats.
  - Expect wr_ready to drop to 0 after the 640th accept.
- Supply only 300 words before vblank.
  - Expect no swap and late_cnt=1.
  - After finishing the remaining 340 words, expect the swap at the following vblank with late_cnt still 1.
- Final accept coincides with vblank_evt.
  - Expect late_cnt increments, no swap until the next vblank, and the col-639 write lands in the back bank.
- Assert i_rst at column 200 of the second frame.
  - Expect all outputs at reset values the next cycle, buffer_sel=1, and a frame_start pulse.
- With RAYCAST_BUF_CLEAR_EN defined, after a swap:
  - Expect 640 zero writes to the new back bank with wr_ready=0.
  - Then a frame_start pulse, then wr_ready=1.

Source files
------------

// File: rtl/raycast_pkg.sv
// Shared types and defaults for the raycast column ping-pong buffer controller.
package raycast_pkg;

  typedef enum logic [1:0] {
    ST_FILL  = 2'd0,
    ST_READY = 2'd1,
    ST_SWAP  = 2'd2,
    ST_CLEAR = 2'd3
  } state_t;

  localparam int NUM_COLS_DEF    = 640;
  localparam int VBLANK_LINE_DEF = 480;

  // 1: display reads bank 1 while the writer fills bank 2; 0: the reverse.
  typedef logic bank_sel_t;
  localparam bank_sel_t SEL_DISP_BANK1 = 1'b1;
  localparam bank_sel_t SEL_DISP_BANK2 = 1'b0;

endpackage

// File: rtl/raycast_buffer_ctrl_bank_write_mux.sv
// Steers one write request to the back bank and registers both banks' write ports;
// the front bank never sees wen and its address/data simply hold.
module bank_write_mux
  import raycast_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 10
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  bank_sel_t         i_buffer_sel,
  input  logic              i_req_valid,
  input  logic [ADDR_W-1:0] i_req_addr,
  input  logic [DATA_W-1:0] i_req_data,
  output logic              o_wen1,
  output logic              o_wen2,
  output logic [ADDR_W-1:0] o_waddr1,
  output logic [ADDR_W-1:0] o_waddr2,
  output logic [DATA_W-1:0] o_wdata1,
  output logic [DATA_W-1:0] o_wdata2
);

  logic              w_to_bank1;
  logic              w_to_bank2;
  logic              r_wen1;
  logic              r_wen2;
  logic [ADDR_W-1:0] r_waddr1;
  logic [ADDR_W-1:0] r_waddr2;
  logic [DATA_W-1:0] r_wdata1;
  logic [DATA_W-1:0] r_wdata2;

  assign w_to_bank1 = i_req_valid && (i_buffer_sel == SEL_DISP_BANK2);
  assign w_to_bank2 = i_req_valid && (i_buffer_sel == SEL_DISP_BANK1);

  // NOTE: non-blocking assignments for every register so all flops sample pre-edge values.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wen1   <= 1'b0;
      r_wen2   <= 1'b0;
      r_waddr1 <= '0;
      r_waddr2 <= '0;
      r_wdata1 <= '0;
      r_wdata2 <= '0;
    end else begin
      r_wen1 <= w_to_bank1;
      r_wen2 <= w_to_bank2;
      if (w_to_bank1) begin
        r_waddr1 <= i_req_addr;
        r_wdata1 <= i_req_data;
      end
      if (w_to_bank2) begin
        r_waddr2 <= i_req_addr;
        r_wdata2 <= i_req_data;
      end
    end
  end

  assign o_wen1   = r_wen1;
  assign o_wen2   = r_wen2;
  assign o_waddr1 = r_waddr1;
  assign o_waddr2 = r_waddr2;
  assign o_wdata1 = r_wdata1;
  assign o_wdata2 = r_wdata2;

endmodule

// File: rtl/raycast_buffer_ctrl.sv
// Ping-pong controller for the raycast column blockmems: fills the back bank, swaps at vblank.
// Optional back-bank zeroing after each swap is enabled by defining RAYCAST_BUF_CLEAR_EN.
module raycast_buffer_ctrl
  import raycast_pkg::*;
#(
  parameter int ADDR_W      = 10,
  parameter int DATA_W      = 10,
  parameter int NUM_COLS    = NUM_COLS_DEF,
  parameter int VBLANK_LINE = VBLANK_LINE_DEF
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [9:0]        i_hp,
  input  logic [9:0]        i_vp,
  input  logic              i_wr_valid,
  input  logic [DATA_W-1:0] i_wr_data,
  output logic              o_wr_ready,
  output logic              o_frame_start,
  output logic              o_wen1,
  output logic              o_wen2,
  output logic [ADDR_W-1:0] o_waddr1,
  output logic [ADDR_W-1:0] o_waddr2,
  output logic [DATA_W-1:0] o_wdata1,
  output logic [DATA_W-1:0] o_wdata2,
  output logic              o_buffer_sel,
  output logic [7:0]        o_late_cnt
);

  localparam logic [ADDR_W-1:0] LAST_COL = ADDR_W'(NUM_COLS - 1);

  state_t            r_state;
  state_t            w_state_next;
  logic [ADDR_W-1:0] r_col;
  logic [ADDR_W-1:0] w_col_next;
  bank_sel_t         r_buffer_sel;
  logic              r_frame_start;
  logic [7:0]        r_late_cnt;

  logic              w_vblank_evt;
  logic              w_accept;
  logic              w_last_col;
  logic              w_swap_enter;
  logic              w_late_evt;
  logic              w_frame_start_next;
  logic              w_req_valid;
  logic [ADDR_W-1:0] w_req_addr;
  logic [DATA_W-1:0] w_req_data;

  assign w_vblank_evt = (i_vp == 10'(VBLANK_LINE)) && (i_hp == 10'd0);
  assign o_wr_ready   = (r_state == ST_FILL) && !i_rst;
  assign w_accept     = i_wr_valid && o_wr_ready;
  assign w_last_col   = (r_col == LAST_COL);

  // NOTE: every combinational output gets a default first so no path infers a latch.
  always_comb begin
    w_state_next       = r_state;
    w_col_next         = r_col;
    w_swap_enter       = 1'b0;
    w_late_evt         = 1'b0;
    w_frame_start_next = 1'b0;
    w_req_valid        = 1'b0;
    w_req_addr         = r_col;
    w_req_data         = i_wr_data;
    case (r_state)
      ST_FILL: begin
        w_late_evt = w_vblank_evt;
        if (w_accept) begin
          w_req_valid = 1'b1;
          if (w_last_col) begin
            w_col_next   = '0;
            w_state_next = ST_READY;
          end else begin
            w_col_next = r_col + 1'b1;
          end
        end
      end
      ST_READY: begin
        if (w_vblank_evt) begin
          w_swap_enter = 1'b1;
          w_state_next = ST_SWAP;
        end
      end
      ST_SWAP: begin
`ifdef RAYCAST_BUF_CLEAR_EN
        w_state_next = ST_CLEAR;
`else
        w_state_next       = ST_FILL;
        w_frame_start_next = 1'b1;
`endif
      end
`ifdef RAYCAST_BUF_CLEAR_EN
      ST_CLEAR: begin
        // Zero the freshly swapped-in back bank before the raycaster refills it.
        w_late_evt  = w_vblank_evt;
        w_req_valid = 1'b1;
        w_req_data  = '0;
        if (w_last_col) begin
          w_col_next         = '0;
          w_state_next       = ST_FILL;
          w_frame_start_next = 1'b1;
        end else begin
          w_col_next = r_col + 1'b1;
        end
      end
`endif
      default: w_state_next = ST_FILL;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state       <= ST_FILL;
      r_col         <= '0;
      r_buffer_sel  <= SEL_DISP_BANK1;
      r_frame_start <= 1'b1;
      r_late_cnt    <= 8'd0;
    end else begin
      r_state       <= w_state_next;
      r_col         <= w_col_next;
      r_frame_start <= w_frame_start_next;
      if (w_swap_enter) begin
        r_buffer_sel <= ~r_buffer_sel;
      end
      if (w_late_evt && (r_late_cnt != 8'hFF)) begin
        r_late_cnt <= r_late_cnt + 8'd1;
      end
    end
  end

  bank_write_mux #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_bank_write_mux (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_buffer_sel(r_buffer_sel),
    .i_req_valid (w_req_valid),
    .i_req_addr  (w_req_addr),
    .i_req_data  (w_req_data),
    .o_wen1      (o_wen1),
    .o_wen2      (o_wen2),
    .o_waddr1    (o_waddr1),
    .o_waddr2    (o_waddr2),
    .o_wdata1    (o_wdata1),
    .o_wdata2    (o_wdata2)
  );

  assign o_frame_start = r_frame_start;
  assign o_buffer_sel  = r_buffer_sel;
  assign o_late_cnt    = r_late_cnt;

endmodule
